fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader.sv | 131 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side burst consumer for the async FIFO (rclk domain).
// Ports: rclk/rrst; start/len/busy command; rempty/rdata/rinc FIFO read port;
//        out_valid/out_ready/out_data/out_last beat stream; done/timeout status.
// Optional: `define FIFO_BURST_TIMEOUT_EN builds a starvation abort counter.
module fifo_burst_reader #(
  parameter int WSIZE   = 16,
  parameter int LSIZE   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic [LSIZE-1:0] len,
  output logic             busy,
  input  logic             rempty,
  input  logic [WSIZE-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WSIZE-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             timeout
);

  // One extra bit so that len = 2^LSIZE-1 loads 2^LSIZE without wrapping.
  localparam int RW = LSIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] remaining;
  logic          accept;
  logic          abort;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be at least 1");
  end

  assign busy   = (state != IDLE);
  assign accept = out_valid && out_ready;

  // Pop only when the output register is free or being emptied this cycle,
  // so a stalled beat is never overwritten and rempty is always honoured.
  assign rinc = (state == BURST) && (remaining != '0) && !rempty &&
                (!out_valid || out_ready);

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] starve_cnt;
  logic          starve;

  // Starved = nothing to pop and nothing pending downstream.
  assign starve = (state == BURST) && rempty && !out_valid;
  // Fires on the edge that would bring the count to TIMEOUT.
  assign abort  = starve && (starve_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      starve_cnt <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= abort;
      if (starve && !abort) begin
        starve_cnt <= starve_cnt + TW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state     <= IDLE;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Output register: load on pop, drain on accept, otherwise hold.
      if (rinc) begin
        out_data  <= rdata;
        out_valid <= 1'b1;
        out_last  <= (remaining == RW'(1));
        remaining <= remaining - RW'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= RW'(len) + RW'(1);
            state     <= BURST;
          end
        end
        BURST: begin
          // abort implies rempty, so it never coincides with a pop.
          if (abort) begin
            remaining <= '0;
            state     <= IDLE;
          end else if (rinc && (remaining == RW'(1))) begin
            state <= LAST;
          end
        end
        LAST: begin
          // The final beat is the only one in flight here.
          if (accept) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench for fifo_burst_reader.
// Ports: none; drives a show-ahead FIFO model and a downstream ready pattern.
// Build with +define+FIFO_BURST_TIMEOUT_EN to exercise the abort path.
module tb_fifo_burst_reader;

  localparam int WSIZE = 16;
  localparam int LSIZE = 8;
`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TO   = 8;
  localparam int GAP1 = 5;
  localparam int GAP2 = 5;
`else
  localparam int TO   = 64;
  localparam int GAP1 = 20;
  localparam int GAP2 = 10;
`endif

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             start = 1'b0;
  logic [LSIZE-1:0] len = '0;
  logic             busy;
  logic             rempty;
  logic [WSIZE-1:0] rdata;
  logic             rinc;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WSIZE-1:0] out_data;
  logic             out_last;
  logic             done;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader #(.WSIZE(WSIZE), .LSIZE(LSIZE), .TIMEOUT(TO)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .len(len), .busy(busy),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .timeout(timeout)
  );

  always #5 rclk = ~rclk;

  // Show-ahead FIFO model: writer pointer owned by stimulus, reader by rinc.
  logic [WSIZE-1:0] mem [0:1023];
  logic [9:0]       wp = '0;
  logic [9:0]       rp = '0;
  assign rempty = (rp == wp);
  assign rdata  = mem[rp];
  always @(posedge rclk) if (rinc) rp <= rp + 10'd1;

  // Observation away from the edge: accepted beats, pulses, protocol hazards.
  logic [WSIZE-1:0] beat_dat [0:1023];
  logic             beat_last [0:1023];
  int beat_cnt = 0, done_cnt = 0, to_cnt = 0;
  int viol_empty = 0, viol_stall = 0, viol_stable = 0, viol_both = 0;
  logic             prev_stall = 1'b0;
  logic [WSIZE-1:0] prev_dat = '0;
  logic             prev_last = 1'b0;

  always @(negedge rclk) begin
    if (rinc && rempty) viol_empty++;
    if (rinc && out_valid && !out_ready) viol_stall++;
    if (done && timeout) viol_both++;
    if (done) done_cnt++;
    if (timeout) to_cnt++;
    if (prev_stall && !rrst &&
        (!out_valid || out_data !== prev_dat || out_last !== prev_last)) viol_stable++;
    prev_stall = out_valid && !out_ready && !rrst;
    prev_dat   = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready && !rrst) begin
      beat_dat[beat_cnt]  = out_data;
      beat_last[beat_cnt] = out_last;
      beat_cnt++;
    end
  end

  task automatic tick;
    @(posedge rclk);
    #2;
  endtask

  task automatic push(input logic [WSIZE-1:0] w);
    mem[wp] = w;
    wp = wp + 10'd1;
  endtask

  task automatic wait_done(input int dbase, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != dbase) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    repeat (2) tick();
    @(negedge rclk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL rst_rinc got %0b exp 0", rinc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", out_data); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_last got %0b exp 0", out_last); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
    checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
    tick();
    rrst = 1'b0;
    tick();
  endtask

  // Cycle-exact table for a 4-beat burst with out_ready held high.
  task automatic test_basic;
    int e_ov[7]   = '{0, 1, 1, 1, 1, 0, 0};
    int e_rinc[7] = '{1, 1, 1, 1, 0, 0, 0};
    int e_busy[7] = '{1, 1, 1, 1, 1, 0, 0};
    int e_last[7] = '{0, 0, 0, 0, 1, 0, 0};
    int e_done[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [WSIZE-1:0] e_dat[7] = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0};
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    out_ready = 1'b1;
    start = 1'b1; len = 8'd3;
    @(negedge rclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got %0b exp 0", busy); end
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge rclk);
      checks++; if (out_valid !== 1'(e_ov[c])) begin errors++; $display("FAIL basic_valid c%0d got %0b exp %0d", c+1, out_valid, e_ov[c]); end
      checks++; if (rinc !== 1'(e_rinc[c]))    begin errors++; $display("FAIL basic_rinc c%0d got %0b exp %0d", c+1, rinc, e_rinc[c]); end
      checks++; if (busy !== 1'(e_busy[c]))    begin errors++; $display("FAIL basic_busy c%0d got %0b exp %0d", c+1, busy, e_busy[c]); end
      checks++; if (out_last !== 1'(e_last[c])) begin errors++; $display("FAIL basic_last c%0d got %0b exp %0d", c+1, out_last, e_last[c]); end
      checks++; if (done !== 1'(e_done[c]))    begin errors++; $display("FAIL basic_done c%0d got %0b exp %0d", c+1, done, e_done[c]); end
      if (e_ov[c] == 1) begin
        checks++; if (out_data !== e_dat[c]) begin errors++; $display("FAIL basic_data c%0d got %0h exp %0h", c+1, out_data, e_dat[c]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    int b = beat_cnt, d = done_cnt, vs = viol_stall, vt = viol_stable;
    logic [WSIZE-1:0] exp_d[3] = '{16'hA001, 16'hA002, 16'hA003};
    push(16'hA001); push(16'hA002); push(16'hA003);
    out_ready = 1'b1;
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d; i++) begin
      out_ready = (i % 3 == 0);
      tick();
    end
    out_ready = 1'b1;
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt - d); end
    checks++; if (beat_cnt - b != 3) begin errors++; $display("FAIL bp_beats got %0d exp 3", beat_cnt - b); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (beat_dat[b+k] !== exp_d[k]) begin errors++; $display("FAIL bp_data%0d got %0h exp %0h", k, beat_dat[b+k], exp_d[k]); end
      checks++; if (beat_last[b+k] !== (k == 2)) begin errors++; $display("FAIL bp_last%0d got %0b exp %0b", k, beat_last[b+k], k == 2); end
    end
    checks++; if (viol_stall != vs)  begin errors++; $display("FAIL bp_rinc_stalled got %0d exp %0d", viol_stall, vs); end
    checks++; if (viol_stable != vt) begin errors++; $display("FAIL bp_stable got %0d exp %0d", viol_stable, vt); end
    tick();
  endtask

  task automatic test_starvation;
    int b = beat_cnt, d = done_cnt, ve = viol_empty;
    bit ok;
    out_ready = 1'b1;
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    repeat (GAP1 - 1) tick();
    @(negedge rclk);
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL starve_busy got %0b exp 1", busy); end
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL starve_rinc got %0b exp 0", rinc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL starve_valid got %0b exp 0", out_valid); end
    tick();
    push(16'h5A01);
    repeat (GAP2) tick();
    push(16'h5A02);
    wait_done(d, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL starve_done_wait got 0 exp 1"); end
    checks++; if (beat_cnt - b != 2) begin errors++; $display("FAIL starve_beats got %0d exp 2", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'h5A01)  begin errors++; $display("FAIL starve_d0 got %0h exp 5a01", beat_dat[b]); end
    checks++; if (beat_dat[b+1] !== 16'h5A02) begin errors++; $display("FAIL starve_d1 got %0h exp 5a02", beat_dat[b+1]); end
    checks++; if (beat_last[b] !== 1'b0 || beat_last[b+1] !== 1'b1) begin errors++; $display("FAIL starve_last got %0b%0b exp 01", beat_last[b], beat_last[b+1]); end
    repeat (3) tick();
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL starve_done_once got %0d exp 1", done_cnt - d); end
    checks++; if (viol_empty != ve)  begin errors++; $display("FAIL starve_rinc_empty got %0d exp %0d", viol_empty, ve); end
  endtask

  task automatic test_len0_ignored_start;
    int b = beat_cnt, d = done_cnt;
    bit ok;
    push(16'hB001);
    out_ready = 1'b1;
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    wait_done(d, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_done_wait got 0 exp 1"); end
    checks++; if (beat_cnt - b != 1) begin errors++; $display("FAIL len0_beats got %0d exp 1", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'hB001 || beat_last[b] !== 1'b1) begin errors++; $display("FAIL len0_beat got %0h/%0b exp b001/1", beat_dat[b], beat_last[b]); end
    tick();
    // Second start (len=5) lands mid-burst and must be ignored.
    b = beat_cnt; d = done_cnt;
    for (int k = 1; k <= 6; k++) push(16'hC000 + 16'(k));
    out_ready = 1'b0;
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    wait_done(d, 20, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_wait got 0 exp 1"); end
    checks++; if (beat_cnt - b != 2) begin errors++; $display("FAIL ign_beats got %0d exp 2", beat_cnt - b); end
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL ign_done_once got %0d exp 1", done_cnt - d); end
    checks++; if (beat_dat[b+1] !== 16'hC002 || beat_last[b+1] !== 1'b1) begin errors++; $display("FAIL ign_last_beat got %0h/%0b exp c002/1", beat_dat[b+1], beat_last[b+1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %0b exp 0", busy); end
    checks++; if (wp - rp != 10'd4) begin errors++; $display("FAIL ign_left got %0d exp 4", wp - rp); end
    // Drain the remaining four words in order.
    b = beat_cnt; d = done_cnt;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    wait_done(d, 20, ok);
    checks++; if (beat_cnt - b != 4) begin errors++; $display("FAIL drain_beats got %0d exp 4", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'hC003 || beat_dat[b+3] !== 16'hC006) begin errors++; $display("FAIL drain_data got %0h..%0h exp c003..c006", beat_dat[b], beat_dat[b+3]); end
    tick();
  endtask

  task automatic test_max_len;
    int b = beat_cnt, d = done_cnt;
    bit ok;
    for (int k = 0; k < 256; k++) push(16'h8000 + 16'(k));
    out_ready = 1'b1;
    start = 1'b1; len = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(d, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_done_wait got 0 exp 1"); end
    checks++; if (beat_cnt - b != 256) begin errors++; $display("FAIL max_beats got %0d exp 256", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'h8000 || beat_dat[b+255] !== 16'h80FF) begin errors++; $display("FAIL max_data got %0h..%0h exp 8000..80ff", beat_dat[b], beat_dat[b+255]); end
    checks++; if (beat_last[b+254] !== 1'b0 || beat_last[b+255] !== 1'b1) begin errors++; $display("FAIL max_last got %0b%0b exp 01", beat_last[b+254], beat_last[b+255]); end
    tick();
  endtask

  task automatic test_reset_mid;
    int b, d;
    bit ok, seen;
    push(16'hD001); push(16'hD002);
    out_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge rclk);
      seen = out_valid;
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_valid_wait got 0 exp 1"); end
    rrst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %0b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rmid_data got %0h exp 0", out_data); end
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL rmid_rinc got %0b exp 0", rinc); end
    tick();
    rrst = 1'b0;
    repeat (3) tick();
    @(negedge rclk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0b/%0b exp 0/0", busy, out_valid); end
    tick();
    b = beat_cnt; d = done_cnt;
    out_ready = 1'b1;
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    wait_done(d, 10, ok);
    checks++; if (beat_cnt - b != 1) begin errors++; $display("FAIL rmid_beats got %0d exp 1", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'hD002 || beat_last[b] !== 1'b1) begin errors++; $display("FAIL rmid_beat got %0h/%0b exp d002/1", beat_dat[b], beat_last[b]); end
    tick();
  endtask

  task automatic test_timeout;
    int b = beat_cnt, d = done_cnt, t = to_cnt;
    push(16'hE001);
    out_ready = 1'b1;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
`ifdef FIFO_BURST_TIMEOUT_EN
    begin
      int hit = 0;
      for (int c = 1; c <= 20 && hit == 0; c++) begin
        @(negedge rclk);
        if (timeout) begin
          hit = c;
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %0b exp 0", busy); end
          checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_done got %0b exp 0", done); end
        end
        tick();
      end
      checks++; if (hit != 11) begin errors++; $display("FAIL to_cycle got %0d exp 11", hit); end
      @(negedge rclk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse got %0b exp 0", timeout); end
      checks++; if (to_cnt - t != 1) begin errors++; $display("FAIL to_count got %0d exp 1", to_cnt - t); end
      tick();
    end
`else
    repeat (30) tick();
    @(negedge rclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_off_busy got %0b exp 1", busy); end
    checks++; if (to_cnt != t) begin errors++; $display("FAIL to_off_pulse got %0d exp %0d", to_cnt, t); end
    tick();
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    tick();
`endif
    checks++; if (beat_cnt - b != 1) begin errors++; $display("FAIL to_beats got %0d exp 1", beat_cnt - b); end
    checks++; if (beat_dat[b] !== 16'hE001 || beat_last[b] !== 1'b0) begin errors++; $display("FAIL to_beat got %0h/%0b exp e001/0", beat_dat[b], beat_last[b]); end
    checks++; if (done_cnt != d) begin errors++; $display("FAIL to_no_done got %0d exp %0d", done_cnt, d); end
    @(negedge rclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got %0b exp 0", busy); end
    checks++; if (viol_both != 0) begin errors++; $display("FAIL done_and_timeout got %0d exp 0", viol_both); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_len0_ignored_start();
    test_max_len();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule
